// File: rtl/mult_div_pkg.sv
// Shared definitions for the multicycle signed multiply/divide engine.
package mult_div_pkg;

  // Default operand width; HI and LO are each this wide.
  localparam int unsigned DefWidth = 32;

  // FSM state encoding, 3 bits.
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StMult = 3'd1,
    StDiv  = 3'd2,
    StFix  = 3'd3,
    StDone = 3'd4
  } state_e;

  // The step counter runs 0..width-1; one spare bit keeps the width safe for any power of two.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

  localparam int unsigned DefCntW = cnt_width(DefWidth);

endpackage

// File: rtl/sdiv_iter.sv
// Single combinational restoring-division step on unsigned magnitudes.
module sdiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // Shift the next dividend bit into the remainder and subtract when it fits.
  always_comb begin
    shifted = {rem_i, quot_i[WIDTH-1]};
    ge      = (shifted >= {1'b0, divisor_i});
    // The difference is below divisor_i whenever it is used, so WIDTH bits are enough.
    diff    = shifted[WIDTH-1:0] - divisor_i;
    rem_o   = ge ? diff : shifted[WIDTH-1:0];
    quot_o  = {quot_i[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) engine feeding HI/LO.
// Optional feature macro: MULT_DIV_DIVZERO_EXC_EN (zero divisor short-cuts to DONE with div_zero).
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mult_control,
  input  logic             DivOp,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             mult_end,
  output logic             busy,
  output logic             div_zero
);

  localparam int unsigned     CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;     // Booth high half (sign-extended) / division remainder
  logic [WIDTH-1:0] qr_q, qr_d;       // Booth multiplier / dividend-then-quotient
  logic             qm1_q, qm1_d;     // Booth q[-1]
  logic [WIDTH-1:0] m_q, m_d;         // multiplicand / |divisor|
  logic             a_neg_q, a_neg_d;
  logic             b_neg_q, b_neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             start_mul, start_div, zero_div, last_step;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH-1:0] rem_nx, quot_nx;

  assign start_mul = (state_q == StIdle) && mult_control;
  assign start_div = (state_q == StIdle) && !mult_control && DivOp;
  assign last_step = (cnt_q == LastCnt);

`ifdef MULT_DIV_DIVZERO_EXC_EN
  assign zero_div = start_div && (B_in == '0);
`else
  assign zero_div = 1'b0;
`endif

  sdiv_iter #(
    .WIDTH (WIDTH)
  ) u_sdiv_iter (
    .rem_i     (acc_q[WIDTH-1:0]),
    .quot_i    (qr_q),
    .divisor_i (m_q),
    .rem_o     (rem_nx),
    .quot_o    (quot_nx)
  );

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      qr_q    <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      qr_q    <= qr_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state logic; multiply wins when both strobes are high.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (mult_control) state_d = StMult;
        else if (DivOp)   state_d = zero_div ? StDone : StDiv;
      end
      StMult:  if (last_step) state_d = StDone;
      StDiv:   if (last_step) state_d = StFix;
      StFix:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath: operand capture, Booth step, restoring step, sign fix, HI/LO load.
  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    qr_d    = qr_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case ({qr_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + {m_q[WIDTH-1], m_q};
      2'b10:   booth_sum = acc_q - {m_q[WIDTH-1], m_q};
      default: booth_sum = acc_q;
    endcase

    if (start_mul) begin
      cnt_d = '0;
      acc_d = '0;
      qr_d  = B_in;
      qm1_d = 1'b0;
      m_d   = A_in;
    end else if (start_div) begin
      cnt_d   = '0;
      acc_d   = '0;
      a_neg_d = A_in[WIDTH-1];
      b_neg_d = B_in[WIDTH-1];
      qr_d    = A_in[WIDTH-1] ? -A_in : A_in;
      m_d     = B_in[WIDTH-1] ? -B_in : B_in;
    end else if (state_q == StMult) begin
      cnt_d = last_step ? '0 : cnt_q + 1'b1;
      // Arithmetic shift right of {acc, qr, q[-1]}.
      acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
      qr_d  = {booth_sum[0], qr_q[WIDTH-1:1]};
      qm1_d = qr_q[0];
    end else if (state_q == StDiv) begin
      cnt_d = last_step ? '0 : cnt_q + 1'b1;
      acc_d = {1'b0, rem_nx};
      qr_d  = quot_nx;
    end else if (state_q == StFix) begin
      qr_d  = (a_neg_q ^ b_neg_q) ? -qr_q : qr_q;
      acc_d = {1'b0, a_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]};
    end

    // HI/LO are loaded on entry to DONE so they are valid alongside mult_end.
    if ((state_d == StDone) && (state_q != StDone) && !zero_div) begin
      hi_d = acc_d[WIDTH-1:0];
      lo_d = qr_d;
    end
  end

`ifdef MULT_DIV_DIVZERO_EXC_EN
  logic dz_q;

  // Remember that DONE was reached through the zero-divisor short-cut.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) dz_q <= 1'b0;
    else          dz_q <= zero_div;
  end
`endif

  // Outputs decoded from state.
  always_comb begin
    HI       = hi_q;
    LO       = lo_q;
    mult_end = (state_q == StDone);
    busy     = (state_q != StIdle);
`ifdef MULT_DIV_DIVZERO_EXC_EN
    div_zero = dz_q && (state_q == StDone);
`else
    div_zero = 1'b0;
`endif
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit; honours MULT_DIV_DIVZERO_EXC_EN when defined.
module tb_mult_div_unit;

  logic        clk;
  logic        reset_n;
  logic        mult_control;
  logic        DivOp;
  logic [31:0] A_in;
  logic [31:0] B_in;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        mult_end;
  logic        busy;
  logic        div_zero;

  int n_assert;
  int n_fail;

  mult_div_unit #(
    .WIDTH (32)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mult_control (mult_control),
    .DivOp        (DivOp),
    .A_in         (A_in),
    .B_in         (B_in),
    .HI           (HI),
    .LO           (LO),
    .mult_end     (mult_end),
    .busy         (busy),
    .div_zero     (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Start an operation at the next edge, then follow it to mult_end and one cycle past.
  task automatic run_op(input logic mul, input logic dv, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cyc, input logic [31:0] ehi,
                        input logic [31:0] elo, input logic edz, input string tag);
    int          cyc;
    logic        busy_bad;
    logic        hold_bad;
    logic [31:0] hi0;
    logic [31:0] lo0;
    hi0          = HI;
    lo0          = LO;
    mult_control = mul;
    DivOp        = dv;
    A_in         = a;
    B_in         = b;
    @(posedge clk); #1;
    mult_control = 1'b0;
    DivOp        = 1'b0;
    A_in         = $urandom;
    B_in         = $urandom;
    cyc          = 1;
    busy_bad     = 1'b0;
    hold_bad     = 1'b0;
    while (!mult_end && cyc < 100) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (HI !== hi0 || LO !== lo0) hold_bad = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, cyc, exp_cyc);
    chk({tag, " busy_during"}, {31'b0, busy_bad}, 32'd0);
    chk({tag, " hilo_hold_during"}, {31'b0, hold_bad}, 32'd0);
    chk({tag, " busy_at_end"}, {31'b0, busy}, 32'd1);
    chk({tag, " HI"}, HI, ehi);
    chk({tag, " LO"}, LO, elo);
    chk({tag, " div_zero"}, {31'b0, div_zero}, {31'b0, edz});
    @(posedge clk); #1;
    chk({tag, " mult_end_width"}, {31'b0, mult_end}, 32'd0);
    chk({tag, " busy_after"}, {31'b0, busy}, 32'd0);
    chk({tag, " HI_hold"}, HI, ehi);
    chk({tag, " LO_hold"}, LO, elo);
  endtask

  initial begin
    logic        end_seen;
    longint      la;
    longint      lb;
    longint      res;
    longint      quo;
    longint      rmd;
    logic [63:0] r64;
    logic [31:0] ra;
    logic [31:0] rb;
    n_assert     = 0;
    n_fail       = 0;
    reset_n      = 1'b0;
    mult_control = 1'b0;
    DivOp        = 1'b0;
    A_in         = '0;
    B_in         = '0;
    #12;
    chk("reset HI", HI, 32'd0);
    chk("reset LO", LO, 32'd0);
    chk("reset flags", {29'b0, mult_end, busy, div_zero}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 7 * -3 = -21
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, 33, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mul7x-3");
    // -7 / 2 = -3 rem -1
    run_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 34, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div-7/2");
`ifdef MULT_DIV_DIVZERO_EXC_EN
    // IDLE -> DONE directly: mult_end in the first cycle after the start edge, HI/LO kept.
    run_op(1'b0, 1'b1, 32'd5, 32'd0, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, "div5/0");
`else
    run_op(1'b0, 1'b1, 32'd5, 32'd0, 34, 32'd5, 32'hFFFFFFFF, 1'b0, "div5/0");
    run_op(1'b0, 1'b1, 32'hFFFFFFFB, 32'd0, 34, 32'hFFFFFFFB, 32'd1, 1'b0, "div-5/0");
`endif
    // Both strobes high: multiply wins.
    run_op(1'b1, 1'b1, 32'h80000000, 32'h80000000, 33, 32'h40000000, 32'd0, 1'b0, "mulmin");
    run_op(1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'd0, 32'd1, 1'b0, "mul-1x-1");
    run_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 34, 32'd0, 32'h80000000, 1'b0, "divmin/-1");
    run_op(1'b0, 1'b1, 32'd7, 32'hFFFFFFFE, 34, 32'd1, 32'hFFFFFFFD, 1'b0, "div7/-2");

    // Divide in flight, ignored restart at cycle 10, reset at cycle 20.
    DivOp = 1'b1;
    A_in  = 32'd100;
    B_in  = 32'd7;
    @(posedge clk); #1;
    DivOp    = 1'b0;
    end_seen = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
      if (mult_end) end_seen = 1'b1;
    end
    DivOp = 1'b1;
    A_in  = 32'd9;
    B_in  = 32'd3;
    @(posedge clk); #1;
    DivOp = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
      if (mult_end) end_seen = 1'b1;
    end
    chk("abort no_end_before_reset", {31'b0, end_seen}, 32'd0);
    chk("abort busy_at_20", {31'b0, busy}, 32'd1);
    chk("abort HI_unchanged", HI, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort reset HI", HI, 32'd0);
    chk("abort reset LO", LO, 32'd0);
    chk("abort reset flags", {29'b0, mult_end, busy, div_zero}, 32'd0);
    @(posedge clk); #1;
    reset_n  = 1'b1;
    end_seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (mult_end || busy) end_seen = 1'b1;
    end
    chk("abort idle_after_reset", {31'b0, end_seen}, 32'd0);
    run_op(1'b1, 1'b0, 32'd3, 32'd4, 33, 32'd0, 32'd12, 1'b0, "mul3x4");

    // Random mixed operations against a 64-bit arithmetic reference.
    for (int i = 0; i < 120; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 0) rb = rb >> 24;
      if (rb == 32'd0) rb = 32'd3;
      la = longint'($signed(ra));
      lb = longint'($signed(rb));
      if (i % 2 == 0) begin
        res = la * lb;
        r64 = res;
        run_op(1'b1, 1'b0, ra, rb, 33, r64[63:32], r64[31:0], 1'b0, "rand_mul");
      end else begin
        quo = la / lb;
        rmd = la % lb;
        r64 = {rmd[31:0], quo[31:0]};
        run_op(1'b0, 1'b1, ra, rb, 34, r64[63:32], r64[31:0], 1'b0, "rand_div");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
